// File: rtl/f_pc_seq.sv
// ============================================================================
// Module      : f_pc_seq
// Description : Fetch-stage program counter sequencer with exception,
//               eret, jump/branch redirect, stall hold and address checking.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module f_pc_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_Jump_addr,
    input  logic        D_Jump_reg,
    input  logic        D_Branch,
    input  logic        B_jump,
    input  logic [25:0] Instr_Index,
    input  logic [31:0] SignImm,
    input  logic [31:0] RD1,
    input  logic [31:0] D_PC,
    output logic [31:0] F_PC,
    output logic        F_BD,
    output logic        F_ExcAdEL,
    output logic        F_kill,
    output logic [1:0]  F_state
);

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] c_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] c_PC_LO    = 32'h0000_3000;
    localparam logic [31:0] c_PC_HI    = 32'h0000_6FFC;

    localparam logic [1:0] c_ST_RUN  = 2'b00;
    localparam logic [1:0] c_ST_HOLD = 2'b01;
    localparam logic [1:0] c_ST_EXC  = 2'b10;

    logic [31:0] r_pc;
    logic [1:0]  r_state;
    logic [31:0] w_pc_next;
    logic [1:0]  w_state_next;
    logic [31:0] w_dpc4;
    logic [31:0] w_br_off;

    assign w_dpc4   = D_PC + 32'd4;
    assign w_br_off = {SignImm[29:0], 2'b00};

    // Redirect priority: Req, stall, eret, j/jal, jr/jalr, taken branch, +4.
    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (Req) begin
            w_pc_next = c_EXC_PC;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (D_eret) begin
            w_pc_next = EPC;
        end else if (D_Jump_addr) begin
            w_pc_next = {w_dpc4[31:28], Instr_Index, 2'b00};
        end else if (D_Jump_reg) begin
            w_pc_next = RD1;
        end else if (B_jump) begin
            w_pc_next = w_dpc4 + w_br_off;
        end
    end

    always_comb begin
        w_state_next = c_ST_RUN;
        if (Req) begin
            w_state_next = c_ST_EXC;
        end else if (stall) begin
            w_state_next = c_ST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= c_RESET_PC;
            r_state <= c_ST_RUN;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
        end
    end

    assign F_PC      = r_pc;
    assign F_state   = r_state;
    assign F_ExcAdEL = (r_pc[1:0] != 2'b00) || (r_pc < c_PC_LO) || (r_pc > c_PC_HI);
    // The handler entry fetched in EXC is never a delay slot.
    assign F_BD      = (D_Jump_addr | D_Jump_reg | D_Branch) & ~D_eret & ~Req
                       & (r_state != c_ST_EXC);
    assign F_kill    = D_eret & ~Req & ~stall;

endmodule

`default_nettype wire

// File: tb/tb_f_pc_seq.sv
// ============================================================================
// Module      : tb_f_pc_seq
// Description : Directed self-checking bench for f_pc_seq.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_f_pc_seq;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        Req;
    logic        D_eret;
    logic [31:0] EPC;
    logic        D_Jump_addr;
    logic        D_Jump_reg;
    logic        D_Branch;
    logic        B_jump;
    logic [25:0] Instr_Index;
    logic [31:0] SignImm;
    logic [31:0] RD1;
    logic [31:0] D_PC;
    logic [31:0] F_PC;
    logic        F_BD;
    logic        F_ExcAdEL;
    logic        F_kill;
    logic [1:0]  F_state;

    int total = 0;
    int bad   = 0;

    f_pc_seq u_dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .Req         (Req),
        .D_eret      (D_eret),
        .EPC         (EPC),
        .D_Jump_addr (D_Jump_addr),
        .D_Jump_reg  (D_Jump_reg),
        .D_Branch    (D_Branch),
        .B_jump      (B_jump),
        .Instr_Index (Instr_Index),
        .SignImm     (SignImm),
        .RD1         (RD1),
        .D_PC        (D_PC),
        .F_PC        (F_PC),
        .F_BD        (F_BD),
        .F_ExcAdEL   (F_ExcAdEL),
        .F_kill      (F_kill),
        .F_state     (F_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; Req = 0; D_eret = 0; D_Jump_addr = 0; D_Jump_reg = 0;
        D_Branch = 0; B_jump = 0;
    endtask

    initial begin
        reset = 1; idle();
        EPC = '0; Instr_Index = '0; SignImm = '0; RD1 = '0; D_PC = '0;
        step(); step();
        reset = 0; #1;
        chk("rst_pc", F_PC, 32'h3000);
        chk("rst_state", {30'd0, F_state}, 32'd0);
        chk("rst_adel", {31'd0, F_ExcAdEL}, 32'd0);
        chk("rst_kill", {31'd0, F_kill}, 32'd0);
        chk("rst_bd", {31'd0, F_BD}, 32'd0);

        step(); chk("seq1", F_PC, 32'h3004);
        step(); chk("seq2", F_PC, 32'h3008);
        step(); chk("seq3", F_PC, 32'h300C);
        chk("seq_state", {30'd0, F_state}, 32'd0);

        // Taken backward branch
        D_PC = 32'h3008; D_Branch = 1; B_jump = 1; SignImm = 32'hFFFF_FFFE; #1;
        chk("br_bd", {31'd0, F_BD}, 32'd1);
        step(); chk("br_pc", F_PC, 32'h3004);
        // Untaken branch still marks delay slot
        B_jump = 0; #1;
        chk("nbr_bd", {31'd0, F_BD}, 32'd1);
        step(); chk("nbr_pc", F_PC, 32'h3008);
        idle();

        // Register jumps and address checking boundaries
        D_Jump_reg = 1; RD1 = 32'h3002;
        step(); chk("jr_pc", F_PC, 32'h3002);
        chk("jr_adel_mis", {31'd0, F_ExcAdEL}, 32'd1);
        RD1 = 32'h7000;
        step(); chk("jr_adel_hi", {31'd0, F_ExcAdEL}, 32'd1);
        RD1 = 32'h6FFC;
        step(); chk("jr_adel_top", {31'd0, F_ExcAdEL}, 32'd0);
        RD1 = 32'h2FFC;
        step(); chk("jr_adel_lo", {31'd0, F_ExcAdEL}, 32'd1);
        RD1 = 32'h3100;
        step(); chk("jr_pc2", F_PC, 32'h3100);
        idle();

        // Stall holds with j pending; target taken on release
        stall = 1; D_Jump_addr = 1; D_PC = 32'h3100; Instr_Index = 26'h0000C80;
        step(); chk("stl_pc1", F_PC, 32'h3100);
        chk("stl_state", {30'd0, F_state}, 32'd1);
        step(); chk("stl_pc2", F_PC, 32'h3100);
        step(); chk("stl_pc3", F_PC, 32'h3100);
        chk("stl_state3", {30'd0, F_state}, 32'd1);
        stall = 0;
        step(); chk("j_pc", F_PC, 32'h3200);
        chk("j_state", {30'd0, F_state}, 32'd0);

        // j upper bits come from D_PC+4
        D_PC = 32'hEFFF_FFFC;
        step(); chk("j_upper", F_PC, 32'hF000_3200);
        chk("j_upper_adel", {31'd0, F_ExcAdEL}, 32'd1);
        idle();

        // Sequential wrap-around
        D_Jump_reg = 1; RD1 = 32'hFFFF_FFFC;
        step(); idle();
        step(); chk("wrap_pc", F_PC, 32'h0000_0000);

        // eret beats j, and stall blocks eret
        D_eret = 1; EPC = 32'h3040; D_Jump_addr = 1; stall = 1; #1;
        chk("eret_stall_kill", {31'd0, F_kill}, 32'd0);
        step(); chk("eret_stall_pc", F_PC, 32'h0000_0000);
        stall = 0; #1;
        chk("eret_kill", {31'd0, F_kill}, 32'd1);
        chk("eret_bd", {31'd0, F_BD}, 32'd0);
        step(); chk("eret_pc", F_PC, 32'h3040);
        idle();

        // Req with stall and eret
        stall = 1; Req = 1; D_eret = 1; EPC = 32'h5000; D_Branch = 1; #1;
        chk("req_kill", {31'd0, F_kill}, 32'd0);
        chk("req_bd", {31'd0, F_BD}, 32'd0);
        step(); chk("req_pc", F_PC, 32'h4180);
        chk("req_state", {30'd0, F_state}, 32'd2);
        chk("req_adel", {31'd0, F_ExcAdEL}, 32'd0);
        idle(); D_Branch = 1; #1;
        chk("exc_bd", {31'd0, F_BD}, 32'd0);
        D_Branch = 0; D_eret = 1; EPC = 32'h3010; #1;
        chk("exc_eret_kill", {31'd0, F_kill}, 32'd1);
        step(); chk("exc_eret_pc", F_PC, 32'h3010);
        chk("exc_eret_state", {30'd0, F_state}, 32'd0);
        idle();

        // EXC followed by stall goes to HOLD
        Req = 1;
        step(); Req = 0; stall = 1;
        step(); chk("exc_hold_state", {30'd0, F_state}, 32'd1);
        chk("exc_hold_pc", F_PC, 32'h4180);

        // Reset during stall with Req pending
        Req = 1; reset = 1;
        step(); reset = 0; idle(); #1;
        chk("rst_mid_pc", F_PC, 32'h3000);
        chk("rst_mid_state", {30'd0, F_state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/f_pc_seq.md
F_PC_SEQ -- requirements
Module: F_PC_SEQ

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 stall  in  1  hazard-unit stall; F and D pipeline registers hold.
REQ-004 Req  in  1  exception/interrupt request from CP0; redirects to handler.
REQ-005 D_eret  in  1  eret in D stage.
REQ-006 EPC  in  32  CP0 exception PC.
REQ-007 D_Jump_addr, D_Jump_reg, D_Branch  in  1 each  D-stage instruction class: j/jal, jr/jalr, any conditional branch.
REQ-008 B_jump  in  1  D-stage branch condition true.
REQ-009 Instr_Index  in  26  D-stage jump index.
REQ-010 SignImm  in  32  D-stage sign-extended offset.
REQ-011 RD1  in  32  forwarded rs value for register jumps.
REQ-012 D_PC  in  32  PC of the D-stage instruction.
REQ-013 F_PC  out  32  fetch address (registered).
REQ-014 F_BD  out  1  F instruction is in a delay slot.
REQ-015 F_ExcAdEL  out  1  F_PC misaligned or outside instruction space.
REQ-016 F_kill  out  1  F instruction must enter D as a nop.
REQ-017 F_state  out  2  FSM state: 00 RUN, 01 HOLD, 10 EXC.

Function
REQ-018 Next-PC priority, highest first: reset, Req, stall, D_eret, D_Jump_addr, D_Jump_reg, B_jump, sequential.
REQ-019 Req: F_PC <= 0x0000_4180 at the next edge regardless of stall, jump or eret.
REQ-020 stall (Req=0): F_PC holds its value; no jump or eret target is taken.
REQ-021 D_eret (Req=0, stall=0): F_PC <= EPC; F_kill=1 combinationally in that cycle.
REQ-022 D_Jump_addr: F_PC <= {D_PC+4 [31:28], Instr_Index, 2'b00}.
REQ-023 D_Jump_reg: F_PC <= RD1, unmodified; misalignment is flagged per REQ-026, never corrected.
REQ-024 B_jump: F_PC <= D_PC + 4 + (SignImm << 2), 32-bit wrap-around.
REQ-025 Otherwise: F_PC <= F_PC + 4, 32-bit wrap-around.
REQ-026 F_ExcAdEL = (F_PC[1:0] != 0) or F_PC < 0x0000_3000 or F_PC > 0x0000_6FFC; combinational from F_PC.
REQ-027 F_BD = (D_Jump_addr | D_Jump_reg | D_Branch) & ~D_eret & ~Req; combinational. It is 1 for untaken branches as well.
REQ-028 F_kill = D_eret & ~Req & ~stall; 0 in every other case.
REQ-029 FSM transitions:
- Any state, Req=1 -> EXC.
- RUN, stall=1 -> HOLD; RUN, stall=0 -> RUN.
- HOLD, stall=1 -> HOLD; HOLD, stall=0 -> RUN.
- EXC, stall=1 -> HOLD; EXC, stall=0 -> RUN.
- EXC lasts exactly one cycle unless Req repeats.
REQ-030 In EXC: F_BD forced 0; the F instruction at 0x4180 is never a delay slot.
REQ-031 Req and D_eret in the same cycle: Req wins; no F_kill; EPC ignored.
REQ-032 stall and any D jump in the same cycle: jump target taken in the first cycle with stall=0, because D is held with the jump.
REQ-033 Zero-cycle latency from D-stage decision to next F_PC; no bubbles inserted except via F_kill.

Reset
REQ-034 On reset=1 at an edge: F_PC <= 0x0000_3000, F_state <= RUN; reset overrides Req and stall.
REQ-035 Outputs after reset: F_BD, F_kill, F_ExcAdEL equal their combinational values; F_ExcAdEL=0 at 0x3000.
REQ-036 Reset asserted mid-stall or mid-EXC returns to RUN at 0x3000 the next edge.

Verification
REQ-037 Reset, then 3 free cycles -> F_PC = 0x3000, 0x3004, 0x3008, 0x300C; F_state=RUN.
REQ-038 D_PC=0x3008, D_Branch=1, B_jump=1, SignImm=0xFFFF_FFFE -> next F_PC=0x3004; F_BD=1 in that cycle.
REQ-039 D_Jump_reg=1, RD1=0x3002 -> F_PC=0x3002, F_ExcAdEL=1. RD1=0x7000 -> F_ExcAdEL=1.
REQ-040 stall=1 for 3 cycles with D_Jump_addr=1 throughout -> F_PC frozen, F_state=HOLD. Release -> F_PC = jump target, F_state=RUN.
REQ-041 Cases for Req and eret:
- Req=1 with stall=1 and D_eret=1 -> F_PC=0x4180, F_state=EXC, F_kill=0, F_BD=0.
- Next cycle D_eret=1, EPC=0x3010 -> F_kill=1, F_PC=0x3010.
